// File: rtl/hcf_sched_pkg.sv
// Shared constants for the HCF job scheduler: FSM state encodings and widths.
package hcf_sched_pkg;

  localparam int ID_W     = 3;
  localparam int TO_CNT_W = 8;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] CAPT = 3'd1;
  localparam logic [2:0] BYP  = 3'd2;
  localparam logic [2:0] LDA  = 3'd3;
  localparam logic [2:0] LDB  = 3'd4;
  localparam logic [2:0] WAIT = 3'd5;
  localparam logic [2:0] RESP = 3'd6;

endpackage

// File: rtl/hcf_job_scheduler_rr_arbiter.sv
// Combinational round-robin pick: lowest set request at or above the pointer,
// otherwise the lowest set request overall (wrap-around).
module rr_arbiter
  import hcf_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [ID_W-1:0] i_ptr,
  output logic [ID_W-1:0] o_gnt_idx,
  output logic            o_gnt_valid
);

  logic            w_hi_found;
  logic [ID_W-1:0] w_hi_idx;
  logic [ID_W-1:0] w_lo_idx;

  // Descending scan so the last hit is the lowest index in each class.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        w_lo_idx = ID_W'(i);
        if (ID_W'(i) >= i_ptr) begin
          w_hi_found = 1'b1;
          w_hi_idx   = ID_W'(i);
        end
      end
    end
    o_gnt_valid = |i_req;
    o_gnt_idx   = w_hi_found ? w_hi_idx : w_lo_idx;
  end

endmodule

// File: rtl/hcf_job_scheduler.sv
// Round-robin scheduler feeding one shared HCF engine; zero operands bypass the engine.
// Optional watchdog on the engine wait is enabled by defining HCF_TIMEOUT_EN.
//
// state | meaning
// IDLE  | arbitrate pending requests
// CAPT  | latch operands of granted requester, pulse ack
// BYP   | a zero operand: result known without the engine
// LDA   | engine start pulse with operand A
// LDB   | operand B on engine data
// WAIT  | wait for engine done (or watchdog expiry)
// RESP  | one-cycle tagged response
module hcf_job_scheduler
  import hcf_sched_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int W           = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] op_a,
  input  logic [NREQ*W-1:0] op_b,
  output logic [NREQ-1:0]   ack,
  output logic              resp_valid,
  output logic [ID_W-1:0]   resp_id,
  output logic [W-1:0]      resp_hcf,
  output logic              resp_err,
  output logic              busy,
  output logic              eng_start,
  output logic [W-1:0]      eng_data,
  output logic              eng_rst,
  input  logic              eng_done,
  input  logic [W-1:0]      eng_result
);

  logic [2:0]      r_state;
  logic [2:0]      w_next;
  logic [ID_W-1:0] r_id;
  logic [ID_W-1:0] r_rr_ptr;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_hcf;
  logic [ID_W-1:0] w_gnt_idx;
  logic            w_gnt_valid;
  logic [W-1:0]    w_cur_a;
  logic [W-1:0]    w_cur_b;
  logic            w_timeout;

  assign w_cur_a = op_a[int'(r_id)*W +: W];
  assign w_cur_b = op_b[int'(r_id)*W +: W];

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_req      (req),
    .i_ptr      (r_rr_ptr),
    .o_gnt_idx  (w_gnt_idx),
    .o_gnt_valid(w_gnt_valid)
  );

`ifdef HCF_TIMEOUT_EN
  logic [TO_CNT_W-1:0] r_to_cnt;
  logic                r_err;

  // Expires on the last of TIMEOUT_CYC wait cycles; a done in that cycle still wins.
  assign w_timeout = (r_state == WAIT) && !eng_done &&
                     (r_to_cnt == TO_CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (r_state == LDB)  r_to_cnt <= '0;
      if (r_state == WAIT) r_to_cnt <= r_to_cnt + 1'b1;
      if (r_state == CAPT) r_err <= 1'b0;
      if (w_timeout)       r_err <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_gnt_valid) w_next = CAPT;
      CAPT:    w_next = (w_cur_a == '0 || w_cur_b == '0) ? BYP : LDA;
      BYP:     w_next = RESP;
      LDA:     w_next = LDB;
      LDB:     w_next = WAIT;
      WAIT:    if (eng_done || w_timeout) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_id     <= '0;
      r_rr_ptr <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_hcf    <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_gnt_valid) r_id <= w_gnt_idx;
        CAPT: begin
          r_a   <= w_cur_a;
          r_b   <= w_cur_b;
          r_hcf <= (w_cur_a == '0) ? w_cur_b : w_cur_a;
        end
        WAIT: begin
          if (eng_done)       r_hcf <= eng_result;
          else if (w_timeout) r_hcf <= '0;
        end
        RESP: r_rr_ptr <= (r_id == ID_W'(NREQ - 1)) ? '0 : r_id + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    ack        = '0;
    resp_valid = 1'b0;
    resp_id    = '0;
    resp_hcf   = '0;
    resp_err   = 1'b0;
    busy       = (r_state != IDLE);
    eng_start  = 1'b0;
    eng_data   = '0;
    eng_rst    = 1'b0;
    case (r_state)
      CAPT: ack = NREQ'(1) << r_id;
      LDA: begin
        eng_start = 1'b1;
        eng_data  = r_a;
      end
      LDB:  eng_data = r_b;
      WAIT: begin
        eng_data = r_b;
        eng_rst  = w_timeout;
      end
      RESP: begin
        // B stays on the engine bus only for jobs that actually used the engine.
        eng_data   = (r_a != '0 && r_b != '0) ? r_b : '0;
        resp_valid = 1'b1;
        resp_id    = r_id;
        resp_hcf   = r_hcf;
`ifdef HCF_TIMEOUT_EN
        resp_err   = r_err;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hcf_job_scheduler.sv
// Self-checking bench for hcf_job_scheduler with a behavioural HCF engine model
// and a response scoreboard; the timeout scenario runs when HCF_TIMEOUT_EN is defined.
module tb_hcf_job_scheduler;
  localparam int NREQ = 4;
  localparam int W    = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*W-1:0] op_a = '0;
  logic [NREQ*W-1:0] op_b = '0;
  logic [NREQ-1:0]   ack;
  logic              resp_valid;
  logic [2:0]        resp_id;
  logic [W-1:0]      resp_hcf;
  logic              resp_err;
  logic              busy;
  logic              eng_start;
  logic [W-1:0]      eng_data;
  logic              eng_rst;
  logic              eng_done = 1'b0;
  logic [W-1:0]      eng_result = '0;

  always #5 clk = ~clk;

  hcf_job_scheduler #(.NREQ(NREQ), .W(W), .TIMEOUT_CYC(20)) dut (
    .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b), .ack(ack),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_hcf(resp_hcf), .resp_err(resp_err),
    .busy(busy), .eng_start(eng_start), .eng_data(eng_data), .eng_rst(eng_rst),
    .eng_done(eng_done), .eng_result(eng_result)
  );

  function automatic logic [W-1:0] gcd(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] t;
    while (y != 0) begin
      t = y;
      y = x % y;
      x = t;
    end
    return x;
  endfunction

  // Engine model: start captures A, next cycle captures B, done after a few cycles.
  logic [W-1:0] m_a = '0, m_b = '0;
  int m_ph = 0, m_lat = 0, m_starts = 0;
  bit m_hang = 1'b0;
  always @(posedge clk) begin
    if (rst || eng_rst) begin
      eng_done <= 1'b0;
      m_ph     <= 0;
    end else if (eng_start) begin
      m_a      <= eng_data;
      m_ph     <= 1;
      eng_done <= 1'b0;
      m_starts <= m_starts + 1;
    end else if (m_ph == 1) begin
      m_b   <= eng_data;
      m_ph  <= 2;
      m_lat <= 5;
    end else if (m_ph == 2) begin
      if (m_lat == 0) begin
        m_ph <= 0;
        if (!m_hang) begin
          eng_done   <= 1'b1;
          eng_result <= gcd(m_a, m_b);
        end
      end else m_lat <= m_lat - 1;
    end
  end

  typedef struct {logic [2:0] id; logic [W-1:0] hcf; logic err;} exp_t;
  typedef struct {int id; logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] hcf; bit eng;} vec_t;
  exp_t q[$];
  vec_t vt[8];
  int n_vec = 0, n_err = 0, n_resp = 0, n_rst_pulse = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (eng_rst) n_rst_pulse++;
    if (resp_valid) begin
      n_resp++;
      if (q.size() == 0) check("resp_unexpected", 64'(q.size()), 64'd1);
      else begin
        e = q.pop_front();
        check("resp", {resp_id, resp_hcf, resp_err}, {e.id, e.hcf, e.err});
      end
    end
  endtask

  task automatic set_ops(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    op_a[id*W +: W] = a;
    op_b[id*W +: W] = b;
  endtask

  task automatic push(input int id, input logic [W-1:0] hcf, input logic err);
    exp_t e;
    e.id = 3'(id); e.hcf = hcf; e.err = err;
    q.push_back(e);
  endtask

  task automatic wait_ack(input int id);
    bit ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      tick();
      if (ack[id]) ok = 1'b1;
    end
    check("ack_seen", 64'(ok), 64'd1);
    check("ack_onehot", 64'(ack), 64'(1) << id);
    check("busy_capt", 64'(busy), 64'd1);
  endtask

  task automatic wait_resp(input int target);
    for (int k = 0; k < 400 && n_resp < target; k++) tick();
    check("resp_seen", 64'(n_resp >= target), 64'd1);
  endtask

  task automatic run_vec(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] hcf, input bit eng, input bit err);
    int s0, tgt;
    s0  = m_starts;
    tgt = n_resp + 1;
    set_ops(id, a, b);
    push(id, hcf, err);
    req[id] = 1'b1;
    wait_ack(id);
    req[id] = 1'b0;
    tick();
    check("ack_pulse", 64'(ack), 64'd0);
    wait_resp(tgt);
    tick();
    check("eng_starts", 64'(m_starts - s0), 64'(eng));
    if (eng) check("eng_seq", {m_a, m_b}, {a, b});
  endtask

  task automatic check_quiet(input string nm);
    check(nm, {ack, resp_valid, resp_id, resp_hcf, resp_err, busy, eng_start, eng_data, eng_rst}, 64'd0);
  endtask

  initial begin
    int na, base, ord[5];
    bit reraise;
    vt[0] = '{0, 143, 78, 13, 1'b1};
    vt[1] = '{2, 0, 36, 36, 1'b0};
    vt[2] = '{1, 0, 0, 0, 1'b0};
    vt[3] = '{3, 25, 0, 25, 1'b0};
    vt[4] = '{1, 48, 18, 6, 1'b1};
    vt[5] = '{3, 65535, 21845, 21845, 1'b1};
    vt[6] = '{2, 17, 13, 1, 1'b1};
    vt[7] = '{0, 100, 100, 100, 1'b1};

    tick(); tick();
    check_quiet("reset_outputs");
    rst = 1'b0;
    tick();
    check_quiet("idle_outputs");

    foreach (vt[i]) run_vec(vt[i].id, vt[i].a, vt[i].b, vt[i].hcf, vt[i].eng, 1'b0);

    // Round-robin from pointer 0; only requester 0 re-raises after its first ack.
    rst = 1'b1; tick(); rst = 1'b0;
    set_ops(0, 12, 18); set_ops(1, 35, 0); set_ops(2, 81, 27); set_ops(3, 7, 5);
    push(0, 6, 0); push(1, 35, 0); push(2, 27, 0); push(3, 1, 0); push(0, 6, 0);
    ord = '{0, 1, 2, 3, 0};
    na = 0; base = n_resp; reraise = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 600 && (na < 5 || n_resp < base + 5); k++) begin
      tick();
      if (ack != '0 && na < 5) begin
        check("rr_order", 64'(ack), 64'(1) << ord[na]);
        check("rr_serial", 64'(n_resp - base), 64'(na));
        req = req & ~ack;
        if (na == 0) reraise = 1'b1;
        na++;
      end else if (reraise) begin
        req[0]  = 1'b1;
        reraise = 1'b0;
      end
    end
    check("rr_grants", 64'(na), 64'd5);
    check("rr_resps", 64'(n_resp - base), 64'd5);

    // Fairness: req[1] held throughout, req[3] raised mid-job.
    req = '0;
    set_ops(1, 20, 8); set_ops(3, 9, 6);
    push(1, 4, 0); push(3, 3, 0); push(1, 4, 0);
    base = n_resp;
    req[1] = 1'b1;
    wait_ack(1);
    tick();
    req[3] = 1'b1;
    wait_ack(3);
    req[3] = 1'b0;
    wait_ack(1);
    req[1] = 1'b0;
    wait_resp(base + 3);

    // Reset while the engine is running: no response, then the job is served again.
    set_ops(1, 48, 18);
    req[1] = 1'b1;
    wait_ack(1);
    tick(); tick(); tick();
    check("busy_wait", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_quiet("abort_outputs");
    base = n_resp;
    push(1, 6, 0);
    wait_ack(1);
    req[1] = 1'b0;
    wait_resp(base + 1);

`ifdef HCF_TIMEOUT_EN
    base = n_rst_pulse;
    m_hang = 1'b1;
    run_vec(2, 30, 12, 0, 1'b1, 1'b1);
    check("eng_rst_pulses", 64'(n_rst_pulse - base), 64'd1);
    m_hang = 1'b0;
    run_vec(2, 21, 14, 7, 1'b1, 1'b0);
`endif

    tick(); tick();
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

endmodule
